regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file for the segmented (pipelined) core, replacing the fixed 32-input read multiplexer with storage, N read ports and a write port. It also has a per-register busy scoreboard for hazard detection in decode. It sits between the decode stage (read and scoreboard-set) and the writeback stage (write and scoreboard-clear).

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers (2..32); register 0 is hardwired zero
NREAD, 2, number of independent read ports (1..4)
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_addr  input  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  output  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NREAD  per-port busy flag of the addressed register
we  input  1  writeback write enable
wr_addr  input  AW  writeback destination register
wr_data  input  XLEN  writeback data
sb_set  input  1  decode issued an instruction writing sb_addr
sb_addr  input  AW  destination of the issued instruction
flush  input  1  pipeline flush; clears all busy bits
busy_vec  output  NREGS  full scoreboard state, for debug and stall logic

Behaviour:
- Reset (rst=1 at an edge): all registers become 0 and all busy bits become 0; rst overrides every other input that cycle. After reset, rd_data=0, rd_busy=0 and busy_vec=0 on all ports.
- Reads are combinational, with zero-cycle latency: rd_data[i]=reg[rd_addr[i]] and rd_busy[i]=busy[rd_addr[i]].
- Address 0: always reads 0 with busy 0. Writes to it are ignored, and sb_set to it is ignored.
- Address >= NREGS (non-power-of-two NREGS): reads 0 with busy 0. Writes and sb_set to it are ignored.
- Write: at the rising edge with we=1 and a valid nonzero wr_addr, reg[wr_addr]<=wr_data. It is visible on read ports from the next cycle, or the same cycle if bypass is enabled (see Optional Feature).
- Scoreboard update per edge, in priority order:
  1) rst clears all busy bits.
  2) flush=1 clears all busy bits. A same-cycle sb_set is discarded, because the issuing instruction is flushed. A same-cycle we still writes data.
  3) sb_set to a valid nonzero sb_addr sets busy[sb_addr]. This wins over a same-cycle clear of the same address, because a newer producer was issued.
  4) we to a valid nonzero wr_addr clears busy[wr_addr].
- sb_set and we to different addresses in the same cycle both take effect.
- sb_set on an already-busy register leaves it busy. The scoreboard tracks a single outstanding producer per register; the pipeline guarantees in-order writeback.
- Multiple read ports with the same address return identical data and busy.
- No internal state other than the register array and the busy vector; no multi-cycle operations.

Optional Feature:
REGFILE_BYPASS_EN:
- Defined: write-to-read forwarding. When we=1 and wr_addr equals rd_addr[i] (nonzero, valid), rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle. The exception is a same-cycle sb_set to that address, where rd_busy[i] stays 1.
- Undefined: in the same-cycle write case, reads return the pre-write register value and the current busy bit. The pipeline must then add one stall cycle.

Test Plan:
- Reset then read: rst=1 for 2 cycles, release, rd_addr={5,0} -> rd_data={0,0}, rd_busy=0, busy_vec=0.
- Write/read: we=1, wr_addr=7, wr_data=0xDEADBEEF; next cycle rd_addr port0=7 -> 0xDEADBEEF. Write to x0 with data 0x1234 -> reading x0 returns 0.
- Scoreboard: sb_set addr 3 -> busy_vec[3]=1 next cycle, rd_busy=1 when reading 3. Then we wr_addr=3 data 0x55 -> busy clears and data reads 0x55. Simultaneous sb_set=3 and we=3 -> busy_vec[3] stays 1 and data is updated.
- Flush: set busy on 4, 9 and 12; flush=1 with sb_set=15 and we wr_addr=4 data 0xA -> busy_vec=0 next cycle, reg4=0xA, reg15 not busy.
- Bypass: we wr_addr=10 data 0x77, rd_addr port1=10 in the same cycle -> with REGFILE_BYPASS_EN, rd_data=0x77 and rd_busy=0 that cycle; without it, the old value is returned that cycle and 0x77 the next.
- Mid-operation reset: busy set on 6 and reg6=0x99; rst=1 concurrent with we wr_addr=6 data 0x11 and sb_set=8 -> all registers 0 and busy_vec=0 after the edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy, w_busy_nx;
  logic             w_wr_ok, w_sb_ok;
  assign w_wr_ok = we && wr_addr != '0 && {1'b0, wr_addr} < NR;
  assign w_sb_ok = sb_set && !flush && sb_addr != '0 && {1'b0, sb_addr} < NR;
  // a newly issued producer outranks the writeback clear of the same register
  always_comb begin
    w_busy_nx = r_busy;
    if (w_wr_ok) w_busy_nx[wr_addr] = 1'b0;
    if (w_sb_ok) w_busy_nx[sb_addr] = 1'b1;
    if (flush) w_busy_nx = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      r_busy <= w_busy_nx;
      if (w_wr_ok) r_regs[wr_addr] <= wr_data;
    end
  end
  assign busy_vec = r_busy;
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_ok;
    assign w_ra = rd_addr[g*AW +: AW];
    assign w_ok = w_ra != '0 && {1'b0, w_ra} < NR;
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit = w_wr_ok && wr_addr == w_ra;
    assign rd_data[g*XLEN +: XLEN] = !w_ok ? '0 : w_hit ? wr_data : r_regs[w_ra];
    assign rd_busy[g] = w_ok && (w_hit ? (w_sb_ok && sb_addr == w_ra) : r_busy[w_ra]);
`else
    assign rd_data[g*XLEN +: XLEN] = w_ok ? r_regs[w_ra] : '0;
    assign rd_busy[g] = w_ok && r_busy[w_ra];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 24, NREAD = 3, AW = $clog2(NREGS);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, we, sb_set, flush;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic [AW-1:0]         wr_addr, sb_addr;
  logic [XLEN-1:0]       wr_data;
  logic [NREGS-1:0]      busy_vec;
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  int n_chk = 0, n_fail = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic bit ok(int a);
    return a > 0 && a < NREGS;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NREGS-1:0] ev;
    for (int p = 0; p < NREAD; p++) begin
      int a;
      bit hit;
      logic [XLEN-1:0] ed;
      bit eb;
      a = int'(rd_addr[p*AW +: AW]);
      hit = BYP && we && ok(int'(wr_addr)) && int'(wr_addr) == a;
      ed = !ok(a) ? '0 : hit ? wr_data : m_reg[a];
      eb = !ok(a) ? 1'b0 : hit ? (sb_set && !flush && int'(sb_addr) == a) : m_busy[a];
      chk($sformatf("rd_data%0d@%0d", p, a), rd_data[p*XLEN +: XLEN], ed);
      chk($sformatf("rd_busy%0d@%0d", p, a), XLEN'(rd_busy[p]), XLEN'(eb));
    end
    for (int r = 0; r < NREGS; r++) ev[r] = m_busy[r];
    chk("busy_vec", XLEN'(busy_vec), XLEN'(ev));
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_reg[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we && ok(int'(wr_addr))) m_reg[wr_addr] = wr_data;
      if (flush) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      end else begin
        if (we && ok(int'(wr_addr))) m_busy[wr_addr] = 1'b0;
        if (sb_set && ok(int'(sb_addr))) m_busy[sb_addr] = 1'b1;
      end
    end
  endtask

  task automatic setin(input bit r, input bit w, input int wa, input logic [XLEN-1:0] wd,
                       input bit s, input int sa, input bit f, input int a0, input int a1, input int a2);
    rst = r; we = w; wr_addr = AW'(wa); wr_data = wd;
    sb_set = s; sb_addr = AW'(sa); flush = f;
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic go(input bit c);
    #1;
    if (c) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int a0, input int a1, input int a2);
    setin(0, 0, 0, '0, 0, 0, 0, a0, a1, a2);
    #1;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r] = '0;
      m_busy[r] = 1'b0;
    end
    setin(1, 0, 0, '0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    go(0);
    setin(1, 1, 5, 32'hFFFF_FFFF, 1, 5, 0, 5, 0, 0);
    go(0);
    idle(5, 0, 9);
    chk("reset_data0", rd_data[0 +: XLEN], '0);
    chk("reset_busy", XLEN'(rd_busy), '0);
    chk("reset_busy_vec", XLEN'(busy_vec), '0);
    go(1);
    setin(0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 7, 0, 0);
    go(1);
    idle(7, 0, 0);
    chk("wr7_read", rd_data[0 +: XLEN], 32'hDEAD_BEEF);
    go(1);
    setin(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    go(1);
    idle(0, 0, 7);
    chk("x0_read", rd_data[0 +: XLEN], '0);
    go(1);
    setin(0, 0, 0, '0, 1, 3, 0, 3, 0, 0);
    go(1);
    idle(3, 3, 0);
    chk("sb3_busy_vec", XLEN'(busy_vec[3]), 1);
    chk("sb3_rd_busy", XLEN'(rd_busy[1:0]), 3);
    go(1);
    setin(0, 1, 3, 32'h55, 0, 0, 0, 3, 0, 0);
    go(1);
    idle(3, 0, 0);
    chk("wb3_data", rd_data[0 +: XLEN], 32'h55);
    chk("wb3_busy", XLEN'(rd_busy[0]), 0);
    go(1);
    setin(0, 1, 3, 32'h66, 1, 3, 0, 3, 0, 0);
    go(1);
    idle(3, 0, 0);
    chk("sbwb3_busy", XLEN'(busy_vec[3]), 1);
    chk("sbwb3_data", rd_data[0 +: XLEN], 32'h66);
    go(1);
    setin(0, 0, 0, '0, 1, 4, 0, 4, 9, 12);
    go(1);
    setin(0, 0, 0, '0, 1, 9, 0, 4, 9, 12);
    go(1);
    setin(0, 0, 0, '0, 1, 12, 0, 4, 9, 12);
    go(1);
    setin(0, 1, 4, 32'hA, 1, 15, 1, 4, 9, 15);
    go(1);
    idle(4, 15, 12);
    chk("flush_busy_vec", XLEN'(busy_vec), '0);
    chk("flush_reg4", rd_data[0 +: XLEN], 32'hA);
    go(1);
    setin(0, 1, 10, 32'h77, 0, 0, 0, 0, 10, 10);
    #1;
    chk("byp_data", rd_data[XLEN +: XLEN], BYP ? 32'h77 : 32'h0);
    chk("byp_busy", XLEN'(rd_busy[1]), 0);
    go(1);
    idle(0, 10, 0);
    chk("byp_next", rd_data[XLEN +: XLEN], 32'h77);
    go(1);
    setin(0, 1, 6, 32'h99, 0, 0, 0, 6, 8, 0);
    go(1);
    setin(0, 0, 0, '0, 1, 6, 0, 6, 8, 0);
    go(1);
    setin(1, 1, 6, 32'h11, 1, 8, 0, 6, 8, 0);
    go(1);
    idle(6, 8, 7);
    chk("mrst_reg6", rd_data[0 +: XLEN], '0);
    chk("mrst_reg7", rd_data[2*XLEN +: XLEN], '0);
    chk("mrst_busy_vec", XLEN'(busy_vec), '0);
    go(1);
    setin(0, 1, 30, 32'hCAFE, 1, 30, 0, 30, 23, 24);
    go(1);
    idle(30, 23, 24);
    chk("oor_data", rd_data[0 +: XLEN], '0);
    chk("oor_busy_vec", XLEN'(busy_vec), '0);
    go(1);
    for (int i = 0; i < 600; i++) begin
      int wa;
      wa = $urandom_range(0, 31);
      setin($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? wa : $urandom_range(0, 31),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0 ? wa : $urandom_range(0, 31),
            $urandom_range(0, 2) == 0 ? wa : $urandom_range(0, 31),
            $urandom_range(0, 31));
      go(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
